// File: rtl/vector_result_checker.sv
// vector_result_checker: compares masked result/expected pairs over valid/ready and reports run statistics
module vector_result_checker #(
    parameter int WIDTH   = 8,
    parameter int SET     = 16,
    parameter int TIMEOUT = 64,
    parameter int CW      = $clog2(SET + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] actual,
    input  logic [WIDTH-1:0] expected,
    input  logic [WIDTH-1:0] mask,
    output logic             busy,
    output logic             done,
    output logic             pass_all,
    output logic [CW-1:0]    pass_count,
    output logic [CW-1:0]    fail_count,
    output logic [CW-1:0]    first_fail_idx,
    output logic [WIDTH-1:0] first_fail_actual,
    output logic [WIDTH-1:0] first_fail_expected,
    output logic             timeout_err,
    output logic             aborted
);
    if (WIDTH < 1 || WIDTH > 1024) begin : g_width_err
        $error("vector_result_checker: WIDTH=%0d outside 1..1024", WIDTH);
    end else if (WIDTH > 256) begin : g_width_warn
        $warning("vector_result_checker: WIDTH=%0d above 256", WIDTH);
    end
    if (SET < 1 || SET > 1000) begin : g_set_err
        $error("vector_result_checker: SET=%0d outside 1..1000", SET);
    end else if (SET > 500) begin : g_set_warn
        $warning("vector_result_checker: SET=%0d above 500", SET);
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE, ABORT} state_t;
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    state_t           r_state, w_state_nxt;
    logic [TW-1:0]    r_idle;
    logic [CW-1:0]    r_pass, r_fail, r_ff_idx;
    logic [WIDTH-1:0] r_ff_act, r_ff_exp;
    logic             r_timeout, r_aborted;
    logic             w_run, w_xfer, w_pass, w_last, w_timeout;

    assign w_run     = r_state == RUN;
    assign in_ready  = w_run && !abort;
    assign w_xfer    = in_valid && in_ready;
    assign w_pass    = ((actual ^ expected) & mask) == '0;
    assign w_last    = r_pass + r_fail == CW'(SET - 1);
    // the counter never exceeds TIMEOUT-1 inside a run, so TW bits suffice
    assign w_timeout = TIMEOUT != 0 && w_run && !w_xfer && r_idle == TW'(TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!w_run) w_state_nxt = start ? RUN : r_state;
        else w_state_nxt = abort ? ABORT : (w_xfer && w_last) ? DONE : w_timeout ? ABORT : RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle    <= '0;
            r_pass    <= '0;
            r_fail    <= '0;
            r_ff_idx  <= '0;
            r_ff_act  <= '0;
            r_ff_exp  <= '0;
            r_timeout <= 1'b0;
            r_aborted <= 1'b0;
        end else if (!w_run && start) begin
            r_idle    <= '0;
            r_pass    <= '0;
            r_fail    <= '0;
            r_ff_idx  <= '0;
            r_ff_act  <= '0;
            r_ff_exp  <= '0;
            r_timeout <= 1'b0;
            r_aborted <= 1'b0;
        end else if (w_run) begin
            if (w_xfer) begin
                r_idle <= '0;
                if (w_pass) r_pass <= r_pass + CW'(1);
                else begin
                    r_fail <= r_fail + CW'(1);
                    if (r_fail == '0) begin
                        r_ff_idx <= r_pass + r_fail;
                        r_ff_act <= actual;
                        r_ff_exp <= expected;
                    end
                end
            end else r_idle <= r_idle + TW'(1);
            if (abort) r_aborted <= 1'b1;
            else if (w_timeout) begin
                r_timeout <= 1'b1;
                r_aborted <= 1'b1;
            end
        end
    end

    assign busy                = w_run;
    assign done                = r_state == DONE;
    assign pass_all            = done && r_fail == '0;
    assign pass_count          = r_pass;
    assign fail_count          = r_fail;
    assign first_fail_idx      = r_ff_idx;
    assign first_fail_actual   = r_ff_act;
    assign first_fail_expected = r_ff_exp;
    assign timeout_err         = r_timeout;
    assign aborted             = r_aborted;
endmodule
